// File: rtl/set_assoc_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types, widths and address-field helpers for the
//               two-way set-associative read cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int LINE_W = 64;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The set index sits just above the byte-in-line offset (8-byte lines).
    function automatic int index_lsb();
        return 3;
    endfunction

    // The tag sits just above the set index.
    function automatic int tag_lsb(input int sets_log2);
        return sets_log2 + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/set_assoc_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : set_assoc_cache_ctrl_if
// Description : Core-side request/ready bus plus SRAM-side fill/write bus of
//               the read cache. The cache is the slave; the core and SRAM
//               controller together form the master side.
// Revision    : 1.0 - initial release
// ============================================================================
interface set_assoc_cache_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output rd_en, wr_en, addr, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/set_assoc_cache_ctrl_way_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_way_array
// Description : One way of the cache: per-set valid bit, tag and two-word
//               line. Combinational read; line fill, word write, valid clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_way_array
    import cache_pkg::*;
#(
    parameter int SETS_LOG2 = 6,
    parameter int TAG_W     = 10
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [SETS_LOG2-1:0] idx_i,
    output logic                      valid_o,
    output logic [TAG_W-1:0]          tag_o,
    output logic [LINE_W-1:0]         line_o,
    input  wire logic                 fill_en_i,
    input  wire logic [TAG_W-1:0]     fill_tag_i,
    input  wire logic [LINE_W-1:0]    fill_line_i,
    input  wire logic                 wr_en_i,
    input  wire logic                 wr_sel_i,
    input  wire logic [WORD_W-1:0]    wr_data_i,
    input  wire logic                 clr_en_i
);
    localparam int SETS = 1 << SETS_LOG2;

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [WORD_W-1:0] lo_q  [SETS];
    logic [WORD_W-1:0] hi_q  [SETS];

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = {hi_q[idx_i], lo_q[idx_i]};

    // Valid bits are the only reset state; a fill sets, an invalidate clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
        end else if (clr_en_i) begin
            valid_q[idx_i] <= 1'b0;
        end
    end

    // Tag and data storage: whole-line fill or single-word write-hit update.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[idx_i] <= fill_tag_i;
            lo_q[idx_i]  <= fill_line_i[WORD_W-1:0];
            hi_q[idx_i]  <= fill_line_i[LINE_W-1:WORD_W];
        end else if (wr_en_i) begin
            if (wr_sel_i) begin
                hi_q[idx_i] <= wr_data_i;
            end else begin
                lo_q[idx_i] <= wr_data_i;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/set_assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : set_assoc_cache_ctrl
// Description : Two-way set-associative write-through, no-write-allocate read
//               cache with LRU replacement and saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int SETS_LOG2     = 6,
    parameter int TAG_W         = 10,
    parameter int WR_HIT_UPDATE = 1,
    parameter int CNT_W         = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    set_assoc_cache_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);
    localparam int SETS    = 1 << SETS_LOG2;
    localparam int IDX_LSB = index_lsb();
    localparam int TAG_LSB = tag_lsb(SETS_LOG2);

    state_e                 state_q, state_d;
    logic [SETS-1:0]        lru_q;
    logic [CNT_W-1:0]       hit_q, miss_q;

    logic [SETS_LOG2-1:0]   w_index;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_word_sel;
    logic [1:0]             w_way_valid;
    logic [TAG_W-1:0]       w_way_tag  [2];
    logic [LINE_W-1:0]      w_way_line [2];
    logic [1:0]             w_hit;
    logic                   w_hit_any, w_hit_way, w_victim;
    logic [LINE_W-1:0]      w_hit_line;
    logic [WORD_W-1:0]      w_hit_word, w_fill_word;
    logic                   w_unused;

    logic                   w_ready, w_sram_rd, w_sram_wr;
    logic [WORD_W-1:0]      w_rdata;
    logic                   w_fill, w_wr_word, w_clr;
    logic                   w_lru_we, w_lru_val, w_hit_inc, w_miss_inc;

    assign w_index    = bus.addr[IDX_LSB +: SETS_LOG2];
    assign w_tag      = bus.addr[TAG_LSB +: TAG_W];
    assign w_word_sel = bus.addr[2];
    assign w_unused   = &{1'b0, bus.addr[1:0]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_way
        cache_way_array #(
            .SETS_LOG2 (SETS_LOG2),
            .TAG_W     (TAG_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .idx_i       (w_index),
            .valid_o     (w_way_valid[gi]),
            .tag_o       (w_way_tag[gi]),
            .line_o      (w_way_line[gi]),
            .fill_en_i   (w_fill & (w_victim == 1'(gi))),
            .fill_tag_i  (w_tag),
            .fill_line_i (bus.sram_rdata),
            .wr_en_i     (w_wr_word & w_hit[gi]),
            .wr_sel_i    (w_word_sel),
            .wr_data_i   (bus.wdata),
            .clr_en_i    (w_clr & w_hit[gi])
        );
        assign w_hit[gi] = w_way_valid[gi] & (w_way_tag[gi] == w_tag);
    end

    assign w_hit_any   = |w_hit;
    assign w_hit_way   = w_hit[1];
    assign w_hit_line  = w_way_line[w_hit_way];
    assign w_hit_word  = w_word_sel ? w_hit_line[LINE_W-1:WORD_W] : w_hit_line[WORD_W-1:0];
    assign w_fill_word = w_word_sel ? bus.sram_rdata[LINE_W-1:WORD_W] : bus.sram_rdata[WORD_W-1:0];
    // Empty ways are filled first (way 0 before way 1); otherwise the LRU way.
    assign w_victim    = ~w_way_valid[0] ? 1'b0 : (~w_way_valid[1] ? 1'b1 : lru_q[w_index]);

    assign bus.ready      = w_ready;
    assign bus.rdata      = w_rdata;
    assign bus.sram_rd_en = w_sram_rd;
    assign bus.sram_wr_en = w_sram_wr;
    assign bus.sram_addr  = (state_q == WRITE) ? {bus.addr[31:2], 2'b00} : {bus.addr[31:3], 3'b000};
    assign bus.sram_wdata = bus.wdata;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state plus all handshake, array-write and bookkeeping strobes.
    always_comb begin
        state_d    = state_q;
        w_ready    = 1'b0;
        w_rdata    = '0;
        w_sram_rd  = 1'b0;
        w_sram_wr  = 1'b0;
        w_fill     = 1'b0;
        w_wr_word  = 1'b0;
        w_clr      = 1'b0;
        w_lru_we   = 1'b0;
        w_lru_val  = 1'b0;
        w_hit_inc  = 1'b0;
        w_miss_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr_en) begin
                    state_d = WRITE;
                end else if (bus.rd_en) begin
                    if (w_hit_any) begin
                        w_ready   = 1'b1;
                        w_rdata   = w_hit_word;
                        w_lru_we  = 1'b1;
                        w_lru_val = ~w_hit_way;
                        w_hit_inc = 1'b1;
                        state_d   = DONE;
                    end else begin
                        w_miss_inc = 1'b1;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                w_sram_rd = 1'b1;
                if (bus.sram_ready) begin
                    w_fill    = 1'b1;
                    w_lru_we  = 1'b1;
                    w_lru_val = ~w_victim;
                    w_ready   = 1'b1;
                    w_rdata   = w_fill_word;
                    state_d   = DONE;
                end
            end
            WRITE: begin
                w_sram_wr = 1'b1;
                if (bus.sram_ready) begin
                    w_ready = 1'b1;
                    if (w_hit_any) begin
                        w_lru_we = 1'b1;
                        if (WR_HIT_UPDATE != 0) begin
                            w_wr_word = 1'b1;
                            w_lru_val = ~w_hit_way;
                        end else begin
                            w_clr     = 1'b1;
                            w_lru_val = w_hit_way;
                        end
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-set LRU bit: names the way to replace on the next fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_q <= '0;
        end else if (w_lru_we) begin
            lru_q[w_index] <= w_lru_val;
        end
    end

    // Saturating read hit / miss statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (w_hit_inc && (hit_q != '1)) begin
                hit_q <= hit_q + 1'b1;
            end
            if (w_miss_inc && (miss_q != '1)) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
